downcount_monitor: RTL and testbench

Registered checker that sits directly downstream of the 4-bit synchronous down-counter and consumes its `out` bus every clock. It locks onto the count sequence, flags any step that is not "previous minus one, modulo 16", counts 0→15 wrap-arounds, and latches the first fault for inspection. It drives the board's fault LED and wrap display, and is the self-check stage for the counter lab.

---
 rtl/downcount_monitor_if.sv | 26 ++
 rtl/downcount_monitor.sv | 147 ++++++++++++++
 tb/tb_downcount_monitor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/downcount_monitor_if.sv
// Bus between the 4-bit down-counter lab and its self-check monitor.
// The counter side (master) drives the sampled count and the fault-clear
// request; the monitor side (slave) returns lock, wrap and fault status.
interface downcount_monitor_if #(
    parameter int WRAP_W = 8
);
    logic [3:0]        cnt_in;
    logic              clr_fault;
    logic              locked;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              fault;
    logic [3:0]        fault_exp;
    logic [3:0]        fault_got;
    logic [7:0]        stall_count;

    modport master (
        output cnt_in, clr_fault,
        input  locked, wrap_pulse, wrap_count, fault, fault_exp, fault_got, stall_count
    );

    modport slave (
        input  cnt_in, clr_fault,
        output locked, wrap_pulse, wrap_count, fault, fault_exp, fault_got, stall_count
    );
endinterface

// File: rtl/downcount_monitor.sv
// downcount_monitor: registered checker for a 4-bit synchronous down-counter.
// Locks onto the "previous minus one, modulo 16" sequence, counts 0->15 wraps
// while locked, and latches the first mismatch (expected / sampled value).
// Optional feature macro: DOWNCOUNT_MON_STALL_EN -- when defined, a repeated
// value (counter held by its clock enable) is legal in SYNC/LOCKED and is
// counted in stall_count; when undefined, a repeat is an ordinary mismatch
// and stall_count is tied to zero.
module downcount_monitor #(
    parameter int WRAP_W   = 8,
    parameter int SYNC_LEN = 2   // 1..15 consecutive good steps to lock
) (
    input logic               clk,
    input logic               rst,
    downcount_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        SYNC    = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [3:0] SYNC_TARGET = 4'(SYNC_LEN);

    // Saturating increment for the wrap counter: sticks at all-ones.
    function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
        return (&v) ? v : v + WRAP_W'(1);
    endfunction

    state_t            state;
    logic [3:0]        prev;
    logic [3:0]        good_cnt;
    logic              locked_q;
    logic              fault_q;
    logic              wrap_pulse_q;
    logic [WRAP_W-1:0] wrap_count_q;
    logic [3:0]        fault_exp_q;
    logic [3:0]        fault_got_q;

    logic [3:0]        exp_val;
    logic              good;
    logic              wrap_hit;
    logic              hold_ok;

    assign exp_val  = prev - 4'd1;
    assign good     = (bus.cnt_in == exp_val);
    assign wrap_hit = good & (prev == 4'd0);

`ifdef DOWNCOUNT_MON_STALL_EN
    // Saturating increment for the 8-bit stall counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    logic       hold;
    logic [7:0] stall_count_q;

    assign hold    = (bus.cnt_in == prev);
    assign hold_ok = hold;

    // Count accepted holds; only SYNC and LOCKED accept a hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= 8'd0;
        end else if (hold && (state == SYNC || state == LOCKED)) begin
            stall_count_q <= sat_inc8(stall_count_q);
        end
    end

    assign bus.stall_count = stall_count_q;
`else
    // Without the stall feature a repeated value is never tolerated.
    assign hold_ok         = 1'b0;
    assign bus.stall_count = 8'd0;
`endif

    // Monitor FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACQUIRE;
            prev         <= 4'd0;
            good_cnt     <= 4'd0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
            fault_exp_q  <= 4'd0;
            fault_got_q  <= 4'd0;
        end else begin
            prev         <= bus.cnt_in;
            wrap_pulse_q <= 1'b0;
            case (state)
                ACQUIRE: begin
                    // First sample only seeds prev; nothing to compare yet.
                    good_cnt <= 4'd0;
                    state    <= SYNC;
                end
                SYNC: begin
                    if (good) begin
                        if (good_cnt + 4'd1 == SYNC_TARGET) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            good_cnt <= 4'd0;
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                        end
                    end else if (!hold_ok) begin
                        good_cnt <= 4'd0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        if (wrap_hit) begin
                            wrap_pulse_q <= 1'b1;
                            wrap_count_q <= sat_inc_wrap(wrap_count_q);
                        end
                    end else if (!hold_ok) begin
                        state       <= FAULT;
                        locked_q    <= 1'b0;
                        fault_q     <= 1'b1;
                        fault_exp_q <= exp_val;
                        fault_got_q <= bus.cnt_in;
                    end
                end
                FAULT: begin
                    // Latched values stay frozen; only clr_fault leaves FAULT,
                    // and the sample on that edge is not checked.
                    if (bus.clr_fault) begin
                        state    <= SYNC;
                        fault_q  <= 1'b0;
                        good_cnt <= 4'd0;
                    end
                end
                default: begin
                    state <= ACQUIRE;
                end
            endcase
        end
    end

    assign bus.locked     = locked_q;
    assign bus.fault      = fault_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.wrap_count = wrap_count_q;
    assign bus.fault_exp  = fault_exp_q;
    assign bus.fault_got  = fault_got_q;
endmodule

// File: tb/tb_downcount_monitor.sv
// Directed bench for downcount_monitor: a vector table for the main scenario
// plus a long locked run on a second instance with a 2-bit wrap counter.
module tb_downcount_monitor;
    localparam bit STALL =
`ifdef DOWNCOUNT_MON_STALL_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    downcount_monitor_if #(.WRAP_W(8)) bus  ();
    downcount_monitor_if #(.WRAP_W(2)) bus2 ();

    assign bus2.cnt_in    = bus.cnt_in;
    assign bus2.clr_fault = bus.clr_fault;

    downcount_monitor #(.WRAP_W(8), .SYNC_LEN(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
    downcount_monitor #(.WRAP_W(2), .SYNC_LEN(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic       rst;
        logic       clr;
        logic [3:0] cnt;
        logic       locked;
        logic       pulse;
        logic [7:0] wc;
        logic       fault;
        logic [3:0] fexp;
        logic [3:0] fgot;
        logic [7:0] stall;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic r, input logic c, input int cnt,
                                input logic lk, input logic p, input int wc,
                                input logic f, input int fe, input int fg, input int st);
        vec_t v;
        v.rst = r; v.clr = c; v.cnt = 4'(cnt);
        v.locked = lk; v.pulse = p; v.wc = 8'(wc);
        v.fault = f; v.fexp = 4'(fe); v.fgot = 4'(fg); v.stall = 8'(st);
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic c, input logic [3:0] v);
        @(negedge clk);
        rst           = r;
        bus.clr_fault = c;
        bus.cnt_in    = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wc2;
        bus.cnt_in    = 4'd0;
        bus.clr_fault = 1'b0;

        // rst clr cnt | locked pulse wc fault fexp fgot stall
        add(1, 0, 0,  0, 0, 0, 0, 0, 0, 0);            // reset state
        add(0, 0, 15, 0, 0, 0, 0, 0, 0, 0);            // edge 1: acquire
        add(0, 0, 14, 0, 0, 0, 0, 0, 0, 0);            // edge 2: good 1
        add(0, 0, 13, 1, 0, 0, 0, 0, 0, 0);            // edge 3: locked
        for (int v = 12; v >= 0; v--) add(0, 0, v, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 15, 1, 1, 1, 0, 0, 0, 0);            // 0->15 wrap
        for (int v = 14; v >= 9; v--) add(0, 0, v, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 7,  0, 0, 1, 1, 8, 7, 0);            // 9 then 7: fault
        add(0, 0, 3,  0, 0, 1, 1, 8, 7, 0);            // later bad: frozen
        add(0, 0, 2,  0, 0, 1, 1, 8, 7, 0);
        add(0, 0, 1,  0, 0, 1, 1, 8, 7, 0);
        add(0, 1, 0,  0, 0, 1, 0, 8, 7, 0);            // clr_fault -> SYNC
        add(0, 0, 15, 0, 0, 1, 0, 8, 7, 0);            // wrap in SYNC not counted
        add(0, 0, 14, 1, 0, 1, 0, 8, 7, 0);            // relocked
        for (int v = 13; v >= 0; v--) add(0, 0, v, 1, 0, 1, 0, 8, 7, 0);
        add(0, 0, 15, 1, 1, 2, 0, 8, 7, 0);            // second wrap
        add(0, 0, 14, 1, 0, 2, 0, 8, 7, 0);
        add(0, 0, 10, 0, 0, 2, 1, 13, 10, 0);          // fault with wc=2
        add(1, 0, 9,  0, 0, 0, 0, 0, 0, 0);            // mid-run reset
        add(0, 0, 9,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 8,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 7,  1, 0, 0, 0, 0, 0, 0);            // relock at 3rd edge
        add(0, 0, 6,  1, 0, 0, 0, 0, 0, 0);
        if (STALL) begin
            add(0, 0, 6, 1, 0, 0, 0, 0, 0, 1);         // accepted hold
            add(0, 0, 5, 1, 0, 0, 0, 0, 0, 1);
        end else begin
            add(0, 0, 6, 0, 0, 0, 1, 5, 6, 0);         // hold is a fault
            add(0, 0, 5, 0, 0, 0, 1, 5, 6, 0);
        end

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].clr, tbl[i].cnt);
            wc2 = (tbl[i].wc > 8'd3) ? 3 : int'(tbl[i].wc);
            chk($sformatf("v%0d locked", i),     32'(bus.locked),      32'(tbl[i].locked));
            chk($sformatf("v%0d wrap_pulse", i), 32'(bus.wrap_pulse),  32'(tbl[i].pulse));
            chk($sformatf("v%0d wrap_count", i), 32'(bus.wrap_count),  32'(tbl[i].wc));
            chk($sformatf("v%0d fault", i),      32'(bus.fault),       32'(tbl[i].fault));
            chk($sformatf("v%0d fault_exp", i),  32'(bus.fault_exp),   32'(tbl[i].fexp));
            chk($sformatf("v%0d fault_got", i),  32'(bus.fault_got),   32'(tbl[i].fgot));
            chk($sformatf("v%0d stall", i),      32'(bus.stall_count), 32'(tbl[i].stall));
            chk($sformatf("v%0d wc2", i),        32'(bus2.wrap_count), 32'(wc2));
        end

        // Long locked run: five wraps, 2-bit counter saturates at 3.
        apply(1'b1, 1'b0, 4'd0);
        chk("sat reset wc", 32'(bus.wrap_count), 32'd0);
        chk("sat reset wc2", 32'(bus2.wrap_count), 32'd0);
        for (int i = 0; i <= 80; i++) begin
            int k;
            logic ep;
            apply(1'b0, 1'b0, 4'(15 - (i % 16)));
            ep = (i > 0) && (i % 16 == 0);
            chk($sformatf("sat i%0d pulse", i),  32'(bus.wrap_pulse),  32'(ep));
            chk($sformatf("sat i%0d pulse2", i), 32'(bus2.wrap_pulse), 32'(ep));
            if (ep) begin
                k = i / 16;
                chk($sformatf("sat i%0d wc", i),  32'(bus.wrap_count),  32'(k));
                chk($sformatf("sat i%0d wc2", i), 32'(bus2.wrap_count), 32'((k > 3) ? 3 : k));
            end
            if (i == 1 || i == 2 || i == 80) begin
                chk($sformatf("sat i%0d locked", i), 32'(bus.locked), 32'(i >= 2));
            end
        end
        chk("sat end fault", 32'(bus.fault), 32'd0);
        chk("sat end fault2", 32'(bus2.fault), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
